// File: rtl/dff_pkg.sv
// Shared limits and sizing helper for the parameterised register stage.
package dff_pkg;

  localparam int DFF_MAX_STAGES = 16;
  localparam int DFF_MAX_WIDTH  = 1024;

  // Bits needed to count 0..stages inclusive; never less than one bit.
  function automatic int clog2_stages(input int stages);
    int w;
    w = 1;
    while ((1 << w) <= stages) w++;
    return w;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One WIDTH-bit register with synchronous active-high reset and clock enable.
module dff_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= RESET_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/dff_sync_reset.sv
// Chain of STAGES enabled registers with a fill counter that flags when the
// output holds data captured since the last reset.
module dff_sync_reset
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_bad_width
    $error("dff_sync_reset: WIDTH out of range 1..1024");
  end
  if (STAGES < 1 || STAGES > DFF_MAX_STAGES) begin : g_bad_stages
    $error("dff_sync_reset: STAGES out of range 1..16");
  end

  localparam int            CW   = clog2_stages(STAGES);
  localparam logic [CW-1:0] FULL = CW'(STAGES);

  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (en),
      .d_i     (chain[k]),
      .q_o     (chain[k+1])
    );
  end

  assign q = chain[STAGES];

  logic [CW-1:0] fill_q, fill_d;
  logic          valid_q;

  always_comb begin
    fill_d = fill_q;
    if (en && fill_q != FULL) begin
      fill_d = fill_q + 1'b1;
    end
  end

  // valid is registered off the next count so it rises on the same edge
  // that the first captured word reaches q.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      valid_q <= (fill_d == FULL);
    end
  end

  assign q_valid = valid_q;

endmodule

// File: tb/tb_dff_sync_reset.sv
// Bench for dff_sync_reset: default 1-bit DFF and an 8-bit, 3-stage pipeline.
module tb_dff_sync_reset;

  logic       clk;
  logic       r0, e0, d0, q0, v0;
  logic       r1, e1, v1;
  logic [7:0] d1, q1;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] PIPE_RV = 8'hA5;
  localparam int         PIPE_S  = 3;

  dff_sync_reset u_dff (
    .clk (clk), .reset (r0), .en (e0), .d (d0), .q (q0), .q_valid (v0)
  );

  dff_sync_reset #(.WIDTH(8), .STAGES(PIPE_S), .RESET_VAL(PIPE_RV)) u_pipe (
    .clk (clk), .reset (r1), .en (e1), .d (d1), .q (q1), .q_valid (v1)
  );

  // Clock: rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic d;
    logic exp_q;
    logic exp_v;
  } vec_t;

  vec_t vecs [12];

  // Reference histories: values captured on enabled edges since last reset.
  logic [0:0] exp_q0 [$];
  logic [7:0] exp_q  [$];

  initial begin
    logic [7:0] want_q;
    logic       want_v;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // reset, d=0
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // reset dominates data
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // release, first capture
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};  // enable hold x3
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // reset beats en=0
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // hold after reset, not valid
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    r0 = 1'b1; e0 = 1'b1; d0 = 1'b0;
    r1 = 1'b1; e1 = 1'b1; d1 = 8'h00;
    #10;

    for (int i = 0; i < 12; i++) begin
      r0 = vecs[i].rst; e0 = vecs[i].en; d0 = vecs[i].d;
      step();
      check($sformatf("vec%0d_q", i), 32'(q0), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_valid", i), 32'(v0), 32'(vecs[i].exp_v));
    end

    // Reset raised between edges must not touch q until the next edge.
    r0 = 1'b1; d0 = 1'b1;
    #3;
    check("mid_reset_before_edge", 32'(q0), 32'd1);
    step();
    check("mid_reset_after_edge_q", 32'(q0), 32'd0);
    check("mid_reset_after_edge_valid", 32'(v0), 32'd0);
    r0 = 1'b0;

    // Pipeline: reset value, then first word reaches q on the third edge.
    check("pipe_reset_q", 32'(q1), 32'(PIPE_RV));
    check("pipe_reset_valid", 32'(v1), 32'd0);
    r1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      d1 = 8'(i);
      step();
      check($sformatf("pipe_fill%0d_q", i), 32'(q1), (i == 3) ? 32'h01 : 32'(PIPE_RV));
      check($sformatf("pipe_fill%0d_valid", i), 32'(v1), (i == 3) ? 32'd1 : 32'd0);
    end
    e1 = 1'b0; d1 = 8'hFF;
    step();
    check("pipe_hold_q", 32'(q1), 32'h01);
    e1 = 1'b1; d1 = 8'h04;
    step();
    check("pipe_resume_q", 32'(q1), 32'h02);

    // Randomised run against the history model; first cycle forces reset.
    for (int i = 0; i < 400; i++) begin
      r0 = (i == 0) || ($urandom_range(0, 19) == 0);
      e0 = 1'($urandom_range(0, 3) != 0);
      d0 = 1'($urandom);
      r1 = (i == 0) || ($urandom_range(0, 19) == 0);
      e1 = 1'($urandom_range(0, 3) != 0);
      d1 = 8'($urandom);
      step();

      if (r0) exp_q0.delete();
      else if (e0) begin
        exp_q0.push_back(d0);
        if (exp_q0.size() > 1) void'(exp_q0.pop_front());
      end
      want_v = (exp_q0.size() == 1);
      want_q = want_v ? 8'(exp_q0[0]) : 8'h00;
      check("rand_dff_q", 32'(q0), 32'(want_q[0]));
      check("rand_dff_valid", 32'(v0), 32'(want_v));

      if (r1) exp_q.delete();
      else if (e1) begin
        exp_q.push_back(d1);
        if (exp_q.size() > PIPE_S) void'(exp_q.pop_front());
      end
      want_v = (exp_q.size() == PIPE_S);
      want_q = want_v ? exp_q[0] : PIPE_RV;
      check("rand_pipe_q", 32'(q1), 32'(want_q));
      check("rand_pipe_valid", 32'(v1), 32'(want_v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
